// File: rtl/if_fetch_unit.sv
// ============================================================================
// Module   : if_fetch_unit
// Purpose  : IF stage. Owns the PC, fetches over req/ack and presents IF->ID.
// Option   : define IF_PREFETCH_EN for overlapped fetch with a 1-entry skid.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef INST_TYPE_NONE
`define INST_TYPE_NONE   4'd0
`define INST_TYPE_ALU_R  4'd1
`define INST_TYPE_ALU_I  4'd2
`define INST_TYPE_LOAD   4'd3
`define INST_TYPE_STORE  4'd4
`define INST_TYPE_BRANCH 4'd5
`define INST_TYPE_JUMP   4'd6
`define INST_TYPE_OTHER  4'd7
`endif

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cu_wpcir,
  input  logic        cu_branch,
  input  logic [31:0] ID_new_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc4,
  output logic [3:0]  IF_ins_type,
  output logic [3:0]  IF_ins_number,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [3:0] c_timeout_last = 4'(ACK_TIMEOUT - 1);

  state_t      r_state;
  logic [31:0] r_pc, r_req_addr, r_inst, r_pc4;
  logic [3:0]  r_type, r_num, r_wait_cnt;
  logic        r_req, r_out_valid, r_drop, r_err;
`ifdef IF_PREFETCH_EN
  logic        r_skid_valid;
  logic [31:0] r_skid_inst, r_skid_pc4;
  logic [3:0]  r_skid_type;
`endif

  logic        w_ack, w_consume;
  logic [31:0] w_addr4;
  logic [3:0]  w_rtype;

  assign w_ack     = r_req & imem_ack;
  assign w_consume = r_out_valid & ~cu_wpcir & ~cu_branch;
  assign w_addr4   = r_req_addr + 32'd4;

  always_comb begin
    w_rtype = `INST_TYPE_OTHER;
    casez (imem_rdata[31:26])
      6'b000000: w_rtype = `INST_TYPE_ALU_R;
      6'b001???: w_rtype = `INST_TYPE_ALU_I;
      6'b100011: w_rtype = `INST_TYPE_LOAD;
      6'b101011: w_rtype = `INST_TYPE_STORE;
      6'b00010?: w_rtype = `INST_TYPE_BRANCH;
      6'b00001?: w_rtype = `INST_TYPE_JUMP;
      default:   w_rtype = `INST_TYPE_OTHER;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_req_addr  <= RESET_PC;
      r_req       <= 1'b0;
      r_inst      <= '0;
      r_pc4       <= '0;
      r_type      <= `INST_TYPE_NONE;
      r_num       <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
      r_drop      <= 1'b0;
      r_wait_cnt  <= '0;
`ifdef IF_PREFETCH_EN
      r_skid_valid <= 1'b0;
      r_skid_inst  <= '0;
      r_skid_pc4   <= '0;
      r_skid_type  <= `INST_TYPE_NONE;
`endif
    end else begin
      if (r_state == S_FETCH && !w_ack && !cu_branch) begin
        if (r_wait_cnt != 4'hF) r_wait_cnt <= r_wait_cnt + 4'd1;
        if (r_wait_cnt >= c_timeout_last) r_err <= 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end

      if (w_consume) r_num <= r_num + 4'd1;
      // Default to a bubble; loads further down override it.
      if (w_consume || cu_branch) begin
        r_out_valid <= 1'b0;
        r_inst      <= '0;
        r_type      <= `INST_TYPE_NONE;
      end
      if (cu_branch) r_pc <= ID_new_pc;

      case (r_state)
        S_IDLE: begin
          r_state    <= S_FETCH;
          r_req      <= 1'b1;
          r_req_addr <= cu_branch ? ID_new_pc : r_pc;
        end

        S_FETCH: begin
          if (w_ack) begin
            if (cu_branch || r_drop) begin
              r_drop     <= 1'b0;
              r_req_addr <= cu_branch ? ID_new_pc : r_pc;
            end else begin
              r_inst      <= imem_rdata;
              r_pc4       <= w_addr4;
              r_type      <= w_rtype;
              r_out_valid <= 1'b1;
              r_pc        <= w_addr4;
              r_state     <= S_HOLD;
`ifdef IF_PREFETCH_EN
              r_req_addr  <= w_addr4;
`else
              r_req       <= 1'b0;
`endif
            end
          end else if (cu_branch) begin
            r_drop <= 1'b1;
          end
        end

        S_HOLD: begin
`ifdef IF_PREFETCH_EN
          if (cu_branch) begin
            r_skid_valid <= 1'b0;
            r_state      <= S_FETCH;
            r_req        <= 1'b1;
            // An outstanding request keeps its address; its late ack is dropped.
            if (r_req && !imem_ack) r_drop <= 1'b1;
            else                    r_req_addr <= ID_new_pc;
          end else if (w_ack) begin
            r_pc <= w_addr4;
            if (w_consume) begin
              r_inst      <= imem_rdata;
              r_pc4       <= w_addr4;
              r_type      <= w_rtype;
              r_out_valid <= 1'b1;
              r_req_addr  <= w_addr4;
            end else begin
              r_skid_valid <= 1'b1;
              r_skid_inst  <= imem_rdata;
              r_skid_pc4   <= w_addr4;
              r_skid_type  <= w_rtype;
              r_req        <= 1'b0;
            end
          end else if (w_consume) begin
            if (r_skid_valid) begin
              r_inst       <= r_skid_inst;
              r_pc4        <= r_skid_pc4;
              r_type       <= r_skid_type;
              r_out_valid  <= 1'b1;
              r_skid_valid <= 1'b0;
              r_req        <= 1'b1;
              r_req_addr   <= r_pc;
            end else begin
              r_state <= S_FETCH;
              r_req   <= 1'b1;
            end
          end
`else
          if (cu_branch) begin
            r_state    <= S_FETCH;
            r_req      <= 1'b1;
            r_req_addr <= ID_new_pc;
          end else if (w_consume) begin
            r_state    <= S_FETCH;
            r_req      <= 1'b1;
            r_req_addr <= r_pc;
          end
`endif
        end

        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req      = r_req;
  assign imem_addr     = r_req_addr;
  assign if_inst       = r_inst;
  assign if_pc4        = r_pc4;
  assign IF_ins_type   = r_type;
  assign IF_ins_number = r_num;
  assign fetch_err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// ============================================================================
// Module   : tb_if_fetch_unit
// Purpose  : Directed self-checking bench for if_fetch_unit with a scoreboard.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef INST_TYPE_NONE
`define INST_TYPE_NONE   4'd0
`define INST_TYPE_ALU_R  4'd1
`define INST_TYPE_ALU_I  4'd2
`define INST_TYPE_LOAD   4'd3
`define INST_TYPE_STORE  4'd4
`define INST_TYPE_BRANCH 4'd5
`define INST_TYPE_JUMP   4'd6
`define INST_TYPE_OTHER  4'd7
`endif

module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, cu_wpcir, cu_branch, auto_ack, man_ack;
  logic [31:0] ID_new_pc;
  logic        imem_req, imem_ack, fetch_err;
  logic [31:0] imem_addr, imem_rdata, if_inst, if_pc4;
  logic [3:0]  IF_ins_type, IF_ins_number;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc4;
    logic [3:0]  typ;
    logic [3:0]  num;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Memory image: opcode picked by addr[4:2], low bits tag the address.
  function automatic logic [5:0] op_at(input logic [31:0] a);
    case (a[4:2])
      3'd0: op_at = 6'b000000;
      3'd1: op_at = 6'b001010;
      3'd2: op_at = 6'b100011;
      3'd3: op_at = 6'b101011;
      3'd4: op_at = 6'b000100;
      3'd5: op_at = 6'b000010;
      3'd6: op_at = 6'b111111;
      default: op_at = 6'b000011;
    endcase
  endfunction

  function automatic logic [3:0] type_at(input logic [31:0] a);
    if (a == 32'h0) return `INST_TYPE_ALU_I;
    case (a[4:2])
      3'd0: type_at = `INST_TYPE_ALU_R;
      3'd1: type_at = `INST_TYPE_ALU_I;
      3'd2: type_at = `INST_TYPE_LOAD;
      3'd3: type_at = `INST_TYPE_STORE;
      3'd4: type_at = `INST_TYPE_BRANCH;
      3'd5: type_at = `INST_TYPE_JUMP;
      3'd6: type_at = `INST_TYPE_OTHER;
      default: type_at = `INST_TYPE_JUMP;
    endcase
  endfunction

  function automatic logic [31:0] inst_at(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return {op_at(a), a[25:0]};
  endfunction

  assign imem_ack   = auto_ack ? imem_req : man_ack;
  assign imem_rdata = inst_at(imem_addr);

  if_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .cu_wpcir     (cu_wpcir),
    .cu_branch    (cu_branch),
    .ID_new_pc    (ID_new_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .if_inst      (if_inst),
    .if_pc4       (if_pc4),
    .IF_ins_type  (IF_ins_type),
    .IF_ins_number(IF_ins_number),
    .fetch_err    (fetch_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [3:0] num);
    exp_t e;
    e.inst = inst_at(a);
    e.pc4  = a + 32'd4;
    e.typ  = type_at(a);
    e.num  = num;
    sb.push_back(e);
  endtask

  task automatic expect_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
      return;
    end
    e = sb.pop_front();
    check({tag, "_inst"}, if_inst, e.inst);
    check({tag, "_pc4"},  if_pc4,  e.pc4);
    check({tag, "_type"}, {28'h0, IF_ins_type}, {28'h0, e.typ});
    check({tag, "_num"},  {28'h0, IF_ins_number}, {28'h0, e.num});
  endtask

  task automatic check_bubble(input string tag, input logic [31:0] pc4, input logic [3:0] num);
    check({tag, "_inst"}, if_inst, 32'h0);
    check({tag, "_type"}, {28'h0, IF_ins_type}, {28'h0, `INST_TYPE_NONE});
    check({tag, "_pc4"},  if_pc4, pc4);
    check({tag, "_num"},  {28'h0, IF_ins_number}, {28'h0, num});
  endtask

  initial begin
    logic [31:0] addr;
    logic [3:0]  num;
    rst = 1'b1; cu_wpcir = 1'b0; cu_branch = 1'b0; ID_new_pc = '0;
    auto_ack = 1'b0; man_ack = 1'b0;
    tick();
    tick();
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_err", {31'h0, fetch_err}, 32'h0);
    check_bubble("rst", 32'h0, 4'd0);

`ifdef IF_PREFETCH_EN
    rst = 1'b0; auto_ack = 1'b1;
    tick();
    check("pf_first_req", {31'h0, imem_req}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      push_exp(32'(4 * i), 4'(i));
      tick();
      expect_out("pf_stream");
      check("pf_req", {31'h0, imem_req}, 32'h1);
    end
    cu_wpcir = 1'b1;
    tick();
`else
    rst = 1'b0; cu_wpcir = 1'b1; auto_ack = 1'b1;
    tick();
    check("fetch0_req",  {31'h0, imem_req}, 32'h1);
    check("fetch0_addr", imem_addr, 32'h0);
    push_exp(32'h0, 4'd0);
    tick();
    expect_out("first");
    check("hold_req", {31'h0, imem_req}, 32'h0);

    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_inst", if_inst, 32'h2008_0005);
      check("stall_pc4",  if_pc4, 32'h4);
      check("stall_num",  {28'h0, IF_ins_number}, 32'h0);
      check("stall_req",  {31'h0, imem_req}, 32'h0);
    end

    cu_wpcir = 1'b0;
    tick();
    cu_wpcir = 1'b1;
    check_bubble("consume0", 32'h4, 4'd1);
    check("next_addr", imem_addr, 32'h4);
    push_exp(32'h4, 4'd1);
    tick();
    expect_out("second");

    // Delayed ack with a branch in the first wait cycle.
    auto_ack = 1'b0; cu_wpcir = 1'b0;
    tick();
    cu_branch = 1'b1; ID_new_pc = 32'h0000_0040;
    tick();
    cu_branch = 1'b0;
    check_bubble("br_wait1", 32'h8, 4'd2);
    check("br_addr_stable", imem_addr, 32'h8);
    tick();
    check_bubble("br_wait2", 32'h8, 4'd2);
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    check_bubble("late_ack", 32'h8, 4'd2);
    check("redirect_req",  {31'h0, imem_req}, 32'h1);
    check("redirect_addr", imem_addr, 32'h40);
    auto_ack = 1'b1; cu_wpcir = 1'b1;
    push_exp(32'h40, 4'd2);
    tick();
    expect_out("target");

    // Redirect near the top of memory and run 17 back-to-back consumes.
    cu_branch = 1'b1; ID_new_pc = 32'hFFFF_FFE0;
    tick();
    cu_branch = 1'b0; cu_wpcir = 1'b0;
    check_bubble("br_hold", 32'h44, 4'd2);
    check("br_hold_addr", imem_addr, 32'hFFFF_FFE0);
    addr = 32'hFFFF_FFE0;
    num  = 4'd2;
    for (int i = 0; i < 17; i++) begin
      push_exp(addr, num);
      tick();
      expect_out("wrap");
      if (i == 16) auto_ack = 1'b0;
      tick();
      addr = addr + 32'd4;
      num  = num + 4'd1;
      check_bubble("wrap_bub", addr, num);
      check("wrap_addr", imem_addr, addr);
    end

    // Ack timeout.
    for (int k = 0; k < 14; k++) tick();
    check("err_before", {31'h0, fetch_err}, 32'h0);
    tick();
    check("err_set", {31'h0, fetch_err}, 32'h1);
    check("err_req", {31'h0, imem_req}, 32'h1);
    check("err_addr", imem_addr, addr);
    cu_wpcir = 1'b1; man_ack = 1'b1;
    push_exp(addr, num);
    tick();
    man_ack = 1'b0;
    expect_out("after_err");
    check("err_sticky", {31'h0, fetch_err}, 32'h1);

    // Reset clears the flag; an ack asserted across reset is ignored.
    rst = 1'b1; man_ack = 1'b1;
    tick();
    rst = 1'b0;
    check("err_clr", {31'h0, fetch_err}, 32'h0);
    check("rst2_req", {31'h0, imem_req}, 32'h0);
    tick();
    check_bubble("rst2_idle", 32'h0, 4'd0);
    man_ack = 1'b0;
    check("rst2_fetch_addr", imem_addr, 32'h0);
`endif

    if (sb.size() != 0) begin
      n_checks++;
      $error("FAIL sb_leftover: observed %0d entries expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
